// File: rtl/ssp_reg_master.sv
// SSP host master: turns one parallel register request into a full SSP
// frame and returns read data as a single-cycle response.
module ssp_reg_master #(
   parameter int pDiv = 2,
   parameter int pGap = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_ra,
   input  logic        req_wnr,
   input  logic [11:0] req_wdat,
   output logic        rsp_valid,
   output logic [11:0] rsp_rdat,
   output logic        busy,
   output logic        SSP_SSEL,
   output logic        SSP_SCK,
   output logic [2:0]  SSP_RA,
   output logic        SSP_WnR,
   output logic        SSP_En,
   output logic        SSP_EOC,
   output logic [11:0] SSP_DI,
   input  logic [11:0] SSP_DO
);

   localparam int CMAX = (pDiv > pGap) ? pDiv : pGap;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] C_DIV = CW'(pDiv - 1);
   localparam logic [CW-1:0] C_GAP = CW'(pGap - 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
   } t_state;

   t_state        r_state, w_nstate;
   logic [CW-1:0] r_cnt, w_ncnt;
   logic [3:0]    r_bcnt, w_nbcnt;
   logic          r_hi, w_nhi;
   logic          w_done, w_acc, w_cap;

   logic          r_ready, r_busy, r_ssel, r_sck;
   logic          r_en, r_eoc, r_rsp, r_wnr;
   logic [2:0]    r_ra;
   logic [11:0]   r_di, r_cap, r_rdat;

   logic          w_ready, w_busy, w_ssel, w_sck;
   logic          w_en, w_eoc, w_rsp;
   logic [11:0]   w_rdat;

   assign w_done = (r_cnt == '0);
   assign w_acc  = (r_state == S_IDLE) && req_valid;
   // Read data is sampled on the final clock of bit 0's high phase
   assign w_cap  = (r_state == S_SHIFT) && r_hi &&
                   (r_bcnt == 4'd0) && w_done;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bcnt  <= '0;
         r_hi    <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_ssel  <= 1'b0;
         r_sck   <= 1'b0;
         r_en    <= 1'b0;
         r_eoc   <= 1'b0;
         r_rsp   <= 1'b0;
         r_rdat  <= '0;
         r_ra    <= '0;
         r_wnr   <= 1'b0;
         r_di    <= '0;
         r_cap   <= '0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_bcnt  <= w_nbcnt;
         r_hi    <= w_nhi;
         r_ready <= w_ready;
         r_busy  <= w_busy;
         r_ssel  <= w_ssel;
         r_sck   <= w_sck;
         r_en    <= w_en;
         r_eoc   <= w_eoc;
         r_rsp   <= w_rsp;
         r_rdat  <= w_rdat;
         if (w_acc) begin
            r_ra  <= req_ra;
            r_wnr <= req_wnr;
            r_di  <= req_wdat;
         end
         if (w_cap)
            r_cap <= SSP_DO;
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nbcnt  = r_bcnt;
      w_nhi    = r_hi;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_nstate = S_SETUP;
               w_ncnt   = C_DIV;
            end
         end
         S_SETUP: begin
            if (w_done) begin
               w_nstate = S_SHIFT;
               w_ncnt   = C_DIV;
               w_nbcnt  = 4'd15;
               w_nhi    = 1'b0;
            end else
               w_ncnt = r_cnt - C_ONE;
         end
         S_SHIFT: begin
            if (!w_done)
               w_ncnt = r_cnt - C_ONE;
            else if (!r_hi) begin
               w_nhi  = 1'b1;
               w_ncnt = C_DIV;
            end else if (r_bcnt == 4'd0) begin
               w_nstate = S_HOLD;
               w_nhi    = 1'b0;
               w_ncnt   = C_DIV;
            end else begin
               w_nbcnt = r_bcnt - 4'd1;
               w_nhi   = 1'b0;
               w_ncnt  = C_DIV;
            end
         end
         S_HOLD: begin
            if (w_done) begin
               w_nstate = S_GAP;
               w_ncnt   = C_GAP;
            end else
               w_ncnt = r_cnt - C_ONE;
         end
         S_GAP: begin
            if (w_done)
               w_nstate = S_IDLE;
            else
               w_ncnt = r_cnt - C_ONE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they come straight off flops
   always_comb begin
      w_ready = (w_nstate == S_IDLE);
      w_busy  = (w_nstate != S_IDLE);
      w_ssel  = (w_nstate == S_SETUP) ||
                (w_nstate == S_SHIFT) ||
                (w_nstate == S_HOLD);
      w_sck   = (w_nstate == S_SHIFT) && w_nhi;
      w_en    = (w_nstate == S_SHIFT) && (w_nbcnt <= 4'd11);
      w_eoc   = (w_nstate == S_SHIFT) && (w_nbcnt == 4'd0);
      w_rsp   = (r_state != S_GAP) && (w_nstate == S_GAP);
      w_rdat  = '0;
      if (w_rsp && !r_wnr)
         w_rdat = r_cap;
   end

   assign req_ready = r_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp;
   assign rsp_rdat  = r_rdat;
   assign SSP_SSEL  = r_ssel;
   assign SSP_SCK   = r_sck;
   assign SSP_RA    = r_ra;
   assign SSP_WnR   = r_wnr;
   assign SSP_En    = r_en;
   assign SSP_EOC   = r_eoc;
   assign SSP_DI    = r_di;

endmodule

// File: tb/tb_ssp_reg_master.sv
// Bench for ssp_reg_master: scoreboard of expected responses, frame
// shape counters, back-to-back, mid-frame reset and fastest-divider checks.
module tb_ssp_reg_master;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_ra = '0;
   logic        req_wnr = 1'b0;
   logic [11:0] req_wdat = '0;
   logic        rsp_valid;
   logic [11:0] rsp_rdat;
   logic        busy;
   logic        SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC;
   logic [2:0]  SSP_RA;
   logic [11:0] SSP_DI;
   logic [11:0] SSP_DO = '0;

   logic        f_valid = 1'b0;
   logic        f_ready;
   logic [2:0]  f_ra = '0;
   logic        f_wnr = 1'b0;
   logic [11:0] f_wdat = '0;
   logic        f_rsp;
   logic [11:0] f_rdat;
   logic        f_busy;
   logic        f_ssel, f_sck, f_wnr_o, f_en, f_eoc;
   logic [2:0]  f_ra_o;
   logic [11:0] f_di;
   logic [11:0] f_do = '0;

   ssp_reg_master #(.pDiv(2), .pGap(2)) u_dut (
      .Clk(Clk), .Rst(Rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ra(req_ra), .req_wnr(req_wnr), .req_wdat(req_wdat),
      .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .busy(busy),
      .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_RA(SSP_RA),
      .SSP_WnR(SSP_WnR), .SSP_En(SSP_En), .SSP_EOC(SSP_EOC),
      .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
   );

   ssp_reg_master #(.pDiv(1), .pGap(1)) u_fast (
      .Clk(Clk), .Rst(Rst),
      .req_valid(f_valid), .req_ready(f_ready),
      .req_ra(f_ra), .req_wnr(f_wnr), .req_wdat(f_wdat),
      .rsp_valid(f_rsp), .rsp_rdat(f_rdat), .busy(f_busy),
      .SSP_SSEL(f_ssel), .SSP_SCK(f_sck), .SSP_RA(f_ra_o),
      .SSP_WnR(f_wnr_o), .SSP_En(f_en), .SSP_EOC(f_eoc),
      .SSP_DI(f_di), .SSP_DO(f_do)
   );

   typedef struct {
      int          cyc;
      logic [11:0] rdat;
   } t_exp;

   t_exp sb[$];
   t_exp fsb[$];
   int   acc_q[$];

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   int   n_sck, n_en, n_eoc, n_ssel, hold_err;
   int   n_acc, n_rsp, min_low, low_run;
   logic prev_sck;
   bit   seen_hi;
   logic [2:0]  e_ra;
   logic        e_wnr;
   logic [11:0] e_di;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic clear_stats();
      n_acc = 0; n_rsp = 0; min_low = 1000;
      low_run = 0; seen_hi = 0; acc_q.delete();
      n_sck = 0; n_en = 0; n_eoc = 0; n_ssel = 0;
      hold_err = 0; prev_sck = 1'b0;
   endtask

   // Observe u_dut for ncyc cycles; drop req_valid after stop_after accepts
   task automatic watch(input int ncyc, input int stop_after);
      t_exp e;
      t_exp g;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge Clk);
         if (req_valid && req_ready) begin
            e.cyc  = cyc + 69;
            e.rdat = req_wnr ? 12'h000 : SSP_DO;
            sb.push_back(e);
            acc_q.push_back(cyc);
            n_acc++;
            e_ra = req_ra; e_wnr = req_wnr; e_di = req_wdat;
            n_sck = 0; n_en = 0; n_eoc = 0; n_ssel = 0;
         end
         if (SSP_SCK && !prev_sck) n_sck++;
         prev_sck = SSP_SCK;
         if (SSP_En)  n_en++;
         if (SSP_EOC) n_eoc++;
         if (SSP_SSEL) begin
            n_ssel++;
            if (seen_hi && low_run > 0 && low_run < min_low)
               min_low = low_run;
            low_run = 0;
            seen_hi = 1;
            if (SSP_RA !== e_ra || SSP_WnR !== e_wnr ||
                SSP_DI !== e_di)
               hold_err++;
         end else
            low_run++;
         if (rsp_valid) begin
            n_rsp++;
            n_chk++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected at cycle %0d", cyc);
            end else begin
               g = sb.pop_front();
               n_chk++;
               if (cyc !== g.cyc) begin
                  n_err++;
                  $display("FAIL rsp_cycle got %0d want %0d",
                           cyc, g.cyc);
               end
               if (rsp_rdat !== g.rdat) begin
                  n_err++;
                  $display("FAIL rsp_rdat got %h want %h",
                           rsp_rdat, g.rdat);
               end
            end
         end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            g = sb.pop_front();
            n_chk++; n_err++;
            $display("FAIL rsp_missing got none want cycle %0d",
                     g.cyc);
         end
         @(posedge Clk);
         #1;
         if (n_acc >= stop_after) req_valid = 1'b0;
      end
      n_chk++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL sb_drain got %0d left want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_frame(input string nm);
      n_chk++;
      if (n_sck !== 16) begin
         n_err++;
         $display("FAIL %s_sck got %0d want 16", nm, n_sck);
      end
      n_chk++;
      if (n_en !== 48) begin
         n_err++;
         $display("FAIL %s_en got %0d want 48", nm, n_en);
      end
      n_chk++;
      if (n_eoc !== 4) begin
         n_err++;
         $display("FAIL %s_eoc got %0d want 4", nm, n_eoc);
      end
      n_chk++;
      if (n_ssel !== 68) begin
         n_err++;
         $display("FAIL %s_ssel got %0d want 68", nm, n_ssel);
      end
      n_chk++;
      if (hold_err !== 0) begin
         n_err++;
         $display("FAIL %s_hold got %0d want 0", nm, hold_err);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_chk++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got %b/%b want 1/0",
                  req_ready, busy);
      end
      n_chk++;
      if ({SSP_SSEL, SSP_SCK, SSP_En, SSP_EOC} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ssp got %b want 0000",
                  {SSP_SSEL, SSP_SCK, SSP_En, SSP_EOC});
      end
      n_chk++;
      if (rsp_valid !== 1'b0 || f_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_rsp got %b/%b want 0/1",
                  rsp_valid, f_ready);
      end
      @(posedge Clk);
      #1 Rst = 1'b0;
   endtask

   task automatic test_write();
      clear_stats();
      req_ra = 3'h2; req_wnr = 1'b1; req_wdat = 12'hA5C;
      req_valid = 1'b1;
      watch(80, 1);
      check_frame("wr");
      n_chk++;
      if (n_rsp !== 1) begin
         n_err++;
         $display("FAIL wr_rsp_count got %0d want 1", n_rsp);
      end
   endtask

   task automatic test_read();
      clear_stats();
      SSP_DO = 12'h3C7;
      req_ra = 3'h5; req_wnr = 1'b0; req_wdat = 12'hFFF;
      req_valid = 1'b1;
      watch(80, 1);
      check_frame("rd");
      n_chk++;
      if (n_rsp !== 1) begin
         n_err++;
         $display("FAIL rd_rsp_count got %0d want 1", n_rsp);
      end
   endtask

   task automatic test_back_to_back();
      clear_stats();
      SSP_DO = 12'h9E1;
      req_ra = 3'h6; req_wnr = 1'b0; req_wdat = 12'h0F0;
      req_valid = 1'b1;
      watch(230, 3);
      n_chk++;
      if (n_acc !== 3 || n_rsp !== 3) begin
         n_err++;
         $display("FAIL b2b_count got %0d/%0d want 3/3",
                  n_acc, n_rsp);
      end
      n_chk++;
      if (acc_q.size() == 3 && (acc_q[1] - acc_q[0] !== 71 ||
          acc_q[2] - acc_q[1] !== 71)) begin
         n_err++;
         $display("FAIL b2b_ready got %0d,%0d want 71,71",
                  acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
      end
      n_chk++;
      if (min_low < 2) begin
         n_err++;
         $display("FAIL b2b_gap got %0d want >=2", min_low);
      end
      check_frame("b2b");
   endtask

   task automatic test_reset_mid();
      int n_bad;
      @(posedge Clk);
      #1;
      SSP_DO = 12'h777;
      req_ra = 3'h4; req_wnr = 1'b0; req_valid = 1'b1;
      @(negedge Clk);
      n_chk++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mr_accept got %b want 1", req_ready);
      end
      @(posedge Clk);
      #1 req_valid = 1'b0;
      repeat (35) @(posedge Clk);
      #1 Rst = 1'b1;
      @(negedge Clk);
      n_chk++;
      if (SSP_En !== 1'b1 || SSP_EOC !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mr_bit7 got %b%b%b want 101",
                  SSP_En, SSP_EOC, busy);
      end
      @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      n_chk++;
      if ({SSP_SSEL, SSP_SCK, SSP_En, SSP_EOC, busy, req_ready}
          !== 6'b000001) begin
         n_err++;
         $display("FAIL mr_idle got %b want 000001",
                  {SSP_SSEL, SSP_SCK, SSP_En, SSP_EOC,
                   busy, req_ready});
      end
      n_bad = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge Clk);
         if (rsp_valid || SSP_SSEL) n_bad++;
      end
      n_chk++;
      if (n_bad !== 0) begin
         n_err++;
         $display("FAIL mr_no_rsp got %0d want 0", n_bad);
      end
      @(posedge Clk);
      #1;
      clear_stats();
      req_ra = 3'h7; req_wnr = 1'b1; req_wdat = 12'h123;
      req_valid = 1'b1;
      watch(80, 1);
      check_frame("mr");
      n_chk++;
      if (n_rsp !== 1) begin
         n_err++;
         $display("FAIL mr_rsp_count got %0d want 1", n_rsp);
      end
   endtask

   task automatic test_fast();
      t_exp e;
      t_exp g;
      int   ft, fr, rises, highs, tog_err, n_frsp;
      logic fprev;
      bit   got;
      ft = -1; fr = -1; rises = 0; highs = 0;
      tog_err = 0; n_frsp = 0; fprev = 1'b0; got = 0;
      @(posedge Clk);
      #1;
      f_ra = 3'h6; f_wnr = 1'b0; f_wdat = 12'hFFF;
      f_do = 12'h5A1; f_valid = 1'b1;
      for (int k = 0; k < 45; k++) begin
         @(negedge Clk);
         if (f_valid && f_ready) begin
            ft = cyc; got = 1;
            e.cyc = cyc + 35; e.rdat = f_do;
            fsb.push_back(e);
         end
         if (got && f_ready && fr < 0 && cyc > ft) fr = cyc;
         if (f_sck) highs++;
         if (f_sck && !fprev) rises++;
         if (f_sck && fprev) tog_err++;
         fprev = f_sck;
         if (f_rsp) begin
            n_frsp++;
            n_chk++;
            if (fsb.size() == 0) begin
               n_err++;
               $display("FAIL fast_rsp_unexpected at %0d", cyc);
            end else begin
               g = fsb.pop_front();
               if (cyc !== g.cyc || f_rdat !== g.rdat) begin
                  n_err++;
                  $display("FAIL fast_rsp got %0d/%h want %0d/%h",
                           cyc, f_rdat, g.cyc, g.rdat);
               end
            end
         end
         @(posedge Clk);
         #1;
         if (got) f_valid = 1'b0;
      end
      n_chk++;
      if (n_frsp !== 1 || fsb.size() !== 0) begin
         n_err++;
         $display("FAIL fast_rsp_count got %0d want 1", n_frsp);
      end
      n_chk++;
      if (rises !== 16 || highs !== 16 || tog_err !== 0) begin
         n_err++;
         $display("FAIL fast_sck got %0d/%0d/%0d want 16/16/0",
                  rises, highs, tog_err);
      end
      n_chk++;
      if (fr - ft !== 36) begin
         n_err++;
         $display("FAIL fast_ready got %0d want 36", fr - ft);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_fast();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
